// File: rtl/qpmm_d0_core.sv
// Quotient-pipelined Montgomery multiplier (quotient delay 0), one K-bit digit of B per stage.
// Build macros: QPMM_FINAL_SUB_EN adds one conditional subtraction of M_tilde in the final
// stage; BLS12_381 selects the 381-bit field, otherwise the 254-bit BN254 field is used.

package CURVE_PARAMS;
`ifdef BLS12_381
  localparam int MOD_W = 381;
  localparam logic [MOD_W-1:0] Mod = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
`else
  localparam int MOD_W = 254;
  localparam logic [MOD_W-1:0] Mod = 254'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
`endif

  localparam int K        = 64;
  localparam int MT_W     = MOD_W + K;        // bits of M_tilde
  localparam int FP_W     = MT_W + 10;        // operands stay below 1024*M_tilde
  // R >= 2^20 * M_tilde keeps Z below 2*M_tilde for any pair of in-range operands.
  localparam int NW       = (MT_W + 20 + K - 1) / K;
  localparam int RB       = K * NW;           // log2(R)
  localparam int LAT_QPMM = NW + 1;

  typedef logic [FP_W-1:0] qpmm_fp_t;
  typedef logic [MT_W:0]   uint_Mtilde2_t;

  // -Mod^-1 mod R by Newton iteration; correct bits double on every step.
  function automatic logic [RB-1:0] calc_neg_inv();
    logic [RB-1:0] x;
    x = RB'(1);
    for (int i = 0; i < 10; i++) x = x * (RB'(2) - RB'(Mod) * x);
    return -x;
  endfunction

  localparam logic [RB-1:0]     NEG_INV  = calc_neg_inv();
  localparam logic [K-1:0]      M_PRIME  = NEG_INV[K-1:0];
  localparam logic [MT_W-1:0]   M_tilde  = MT_W'(M_PRIME) * MT_W'(Mod);
  localparam logic [RB+MOD_W:0] RINV_NUM = (RB+MOD_W+1)'(NEG_INV) * (RB+MOD_W+1)'(Mod)
                                         + (RB+MOD_W+1)'(1);
  localparam logic [MOD_W-1:0]  R_INV    = MOD_W'(RINV_NUM >> RB);
endpackage

module qpmm_d0_core
  import CURVE_PARAMS::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  qpmm_fp_t      A,
  input  qpmm_fp_t      B,
  output uint_Mtilde2_t Z
);
  localparam int SW = FP_W + K + 1;   // S_i < (2^K+1)*A + 2*M_tilde
  localparam int PW = K + MT_W;       // q * M_tilde
  localparam int BW = K + FP_W;       // b_i * A

  typedef logic [SW-1:0] s_t;

  // Input capture stage a_r[0]/b_r[0], then s_r[i] holds S_{i+1} with its A and
  // the not-yet-consumed B digits shifted down so b_i is always in the low K bits.
  s_t            s_r   [NW];
  qpmm_fp_t      a_r   [NW];
  logic [RB-1:0] b_r   [NW];
  s_t            s_nxt [NW];

  s_t            s_cur;
  qpmm_fp_t      a_cur;
  logic [RB-1:0] b_cur;
  logic [K-1:0]  q;
  logic [SW:0]   t;

  logic [K-1:0]  q_f;
  logic [SW:0]   t_f;
  uint_Mtilde2_t z_raw;
  uint_Mtilde2_t z_nxt;

  // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
  always_comb begin
    s_cur = '0;
    a_cur = '0;
    b_cur = '0;
    q     = '0;
    t     = '0;
    for (int i = 0; i < NW; i++) begin
      a_cur    = a_r[i];
      b_cur    = b_r[i];
      q        = s_cur[K-1:0];
      // Low K bits of t are zero because M_tilde = -1 mod 2^K, so the shift is exact.
      t        = (SW+1)'(s_cur) + (SW+1)'(PW'(q) * PW'(M_tilde));
      s_nxt[i] = SW'(t >> K) + SW'(BW'(b_cur[K-1:0]) * BW'(a_cur));
      s_cur    = s_r[i];
    end
  end

  always_comb begin
    q_f   = s_r[NW-1][K-1:0];
    t_f   = (SW+1)'(s_r[NW-1]) + (SW+1)'(PW'(q_f) * PW'(M_tilde));
    z_raw = uint_Mtilde2_t'(t_f >> K);
`ifdef QPMM_FINAL_SUB_EN
    z_nxt = (z_raw >= (MT_W+1)'(M_tilde)) ? z_raw - (MT_W+1)'(M_tilde) : z_raw;
`else
    z_nxt = z_raw;
`endif
  end

  // NOTE: non-blocking assignments let every stage capture its predecessor's pre-edge value.
  // NOTE: all datapath registers are cleared so a reset flushes in-flight work to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NW; i++) begin
        s_r[i] <= '0;
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
      Z <= '0;
    end else begin
      a_r[0] <= A;
      b_r[0] <= RB'(B);
      for (int i = 1; i < NW; i++) begin
        a_r[i] <= a_r[i-1];
        b_r[i] <= b_r[i-1] >> K;
      end
      for (int i = 0; i < NW; i++) s_r[i] <= s_nxt[i];
      Z <= z_nxt;
    end
  end
endmodule

// File: tb/tb_qpmm_d0_core.sv
// Randomized bench for qpmm_d0_core: every result is checked through Z*R == A*B (mod Mod),
// which is MR(Z) == MR(A)*MR(B) mod Mod with MR(x) = x*R^-1 mod Mod.
module tb_qpmm_d0_core;
  import CURVE_PARAMS::*;

  typedef logic [1023:0] wide_t;

  localparam int RST_AT   = 12;
  localparam int RST_HOLD = 10;

  logic          clk;
  logic          rstn;
  qpmm_fp_t      A;
  qpmm_fp_t      B;
  uint_Mtilde2_t Z;

  int    checks;
  int    failures;
  wide_t a_lim;   // 1024 * M_tilde, exclusive operand bound
  wide_t r_mod;   // R mod Mod, the Montgomery form of one

  qpmm_d0_core dut (.clk(clk), .rstn(rstn), .A(A), .B(B), .Z(Z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic qpmm_fp_t rand_op();
    wide_t v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0:       v = v % wide_t'(Mod);
      1:       v = a_lim - wide_t'(1) - (v % wide_t'(256));
      default: v = v % a_lim;
    endcase
    return qpmm_fp_t'(v);
  endfunction

  function automatic wide_t ref_prod(input qpmm_fp_t a, input qpmm_fp_t b);
    return (wide_t'(a) * wide_t'(b)) % wide_t'(Mod);
  endfunction

  function automatic wide_t z_scaled(input uint_Mtilde2_t z);
    return (wide_t'(z) << RB) % wide_t'(Mod);
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      A = rand_op();
      B = rand_op();
      tick();
      checks++;
      if (Z !== '0) begin
        failures++;
        $display("FAIL reset[%0d] Z=%h required=0", c, Z);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_zero();
    wide_t got;
    for (int c = 0; c < 6 + LAT_QPMM; c++) begin
      A = '0;
      B = rand_op();
      tick();
      if (c >= LAT_QPMM) begin
        got = wide_t'(Z) % wide_t'(Mod);
        checks++;
        if (got !== '0) begin
          failures++;
          $display("FAIL zero_operand[%0d] Z%%Mod=%h required=0", c, got[MOD_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_mont_one();
    qpmm_fp_t qb[$];
    qpmm_fp_t b0;
    wide_t    got;
    wide_t    exp_v;
    for (int c = 0; c < 8 + LAT_QPMM; c++) begin
      A = qpmm_fp_t'(r_mod);
      B = rand_op();
      qb.push_back(B);
      tick();
      if (c >= LAT_QPMM) begin
        b0    = qb.pop_front();
        got   = wide_t'(Z) % wide_t'(Mod);
        exp_v = wide_t'(b0) % wide_t'(Mod);
        checks++;
        if (got !== exp_v) begin
          failures++;
          $display("FAIL mont_one[%0d] Z%%Mod=%h required=%h", c, got[MOD_W-1:0], exp_v[MOD_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_max_range();
    qpmm_fp_t amax;
    wide_t    got;
    wide_t    exp_v;
    amax  = qpmm_fp_t'(a_lim - wide_t'(1));
    exp_v = ref_prod(amax, amax);
    for (int c = 0; c < 8 + LAT_QPMM; c++) begin
      A = amax;
      B = amax;
      tick();
      if (c >= LAT_QPMM) begin
        got = z_scaled(Z);
        checks++;
        if (got !== exp_v) begin
          failures++;
          $display("FAIL max_range[%0d] Z*R%%Mod=%h required=%h", c, got[MOD_W-1:0], exp_v[MOD_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    qpmm_fp_t qa[$];
    qpmm_fp_t qb[$];
    qpmm_fp_t a0;
    qpmm_fp_t b0;
    wide_t    got;
    wide_t    exp_v;
    for (int c = 0; c < n + LAT_QPMM; c++) begin
      if (c < n) begin
        A = rand_op();
        B = rand_op();
      end
      qa.push_back(A);
      qb.push_back(B);
      tick();
      if (c >= LAT_QPMM) begin
        a0    = qa.pop_front();
        b0    = qb.pop_front();
        got   = z_scaled(Z);
        exp_v = ref_prod(a0, b0);
        checks++;
        if (got !== exp_v) begin
          failures++;
          $display("FAIL random[%0d] Z*R%%Mod=%h required=%h", c - LAT_QPMM, got[MOD_W-1:0], exp_v[MOD_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    qpmm_fp_t qa[$];
    qpmm_fp_t qb[$];
    qpmm_fp_t a0;
    qpmm_fp_t b0;
    wide_t    got;
    wide_t    exp_v;
    for (int c = 0; c < RST_AT + RST_HOLD + LAT_QPMM + 8; c++) begin
      rstn = (c >= RST_AT && c < RST_AT + RST_HOLD) ? 1'b0 : 1'b1;
      A = rand_op();
      B = rand_op();
      if (!rstn) begin
        qa.delete();
        qb.delete();
      end else begin
        qa.push_back(A);
        qb.push_back(B);
      end
      tick();
      if (c >= RST_AT && c < RST_AT + RST_HOLD + LAT_QPMM) begin
        checks++;
        if (Z !== '0) begin
          failures++;
          $display("FAIL mid_reset_zero[%0d] Z=%h required=0", c, Z);
        end
      end else if (qa.size() > LAT_QPMM) begin
        a0    = qa.pop_front();
        b0    = qb.pop_front();
        got   = z_scaled(Z);
        exp_v = ref_prod(a0, b0);
        checks++;
        if (got !== exp_v) begin
          failures++;
          $display("FAIL mid_reset_result[%0d] Z*R%%Mod=%h required=%h", c, got[MOD_W-1:0], exp_v[MOD_W-1:0]);
        end
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    A        = '0;
    B        = '0;
    a_lim    = wide_t'(M_tilde) << 10;
    r_mod    = (wide_t'(1) << RB) % wide_t'(Mod);

    test_reset();
    test_zero();
    test_mont_one();
    test_max_range();
    test_random(400);
    test_mid_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
